// File: rtl/altpcierd_cdma_msi_gen.sv
// MSI request generator for the chaining DMA: merges read/write descriptor-engine
// interrupt pulses into per-source pending bits and issues one MSI at a time.
module altpcierd_cdma_msi_gen #(
    parameter logic [2:0] MSI_TC     = 3'd0,
    parameter int         GAP_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rstn,
    input  logic       msi_enable,
    input  logic       rd_irq,
    input  logic [4:0] rd_irq_num,
    input  logic       wr_irq,
    input  logic [4:0] wr_irq_num,
    output logic       app_msi_req,
    input  logic       app_msi_ack,
    output logic [2:0] app_msi_tc,
    output logic [4:0] app_msi_num,
    output logic       msi_busy,
    output logic [7:0] coalesce_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

    localparam logic SRC_RD = 1'b0;
    localparam logic SRC_WR = 1'b1;

    state_t     state;
    logic       rd_pend, wr_pend;
    logic       rd_pend_p1, wr_pend_p1;
    logic [4:0] rd_num_q, wr_num_q;
    logic       last_gnt, gnt_q;
    logic [3:0] gap_cnt;

    logic       ack_fire, rd_clr, wr_clr, rd_merge, wr_merge;
    logic       rd_rdy, wr_rdy, gnt_sel;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        ack_fire = (state == REQ) && app_msi_ack;
        rd_clr   = ack_fire && (gnt_q == SRC_RD);
        wr_clr   = ack_fire && (gnt_q == SRC_WR);
        rd_merge = rd_irq && rd_pend && !rd_clr;
        wr_merge = wr_irq && wr_pend && !wr_clr;
        // A source is eligible only once its bit has been set for a full cycle.
        rd_rdy   = rd_pend && rd_pend_p1;
        wr_rdy   = wr_pend && wr_pend_p1;
        if (rd_rdy && wr_rdy)
            gnt_sel = ~last_gnt;
        else
            gnt_sel = wr_rdy ? SRC_WR : SRC_RD;
    end

    // Stage p0: pending capture and coalescing; p1: pending age for eligibility
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            rd_pend      <= 1'b0;
            wr_pend      <= 1'b0;
            rd_pend_p1   <= 1'b0;
            wr_pend_p1   <= 1'b0;
            rd_num_q     <= 5'd0;
            wr_num_q     <= 5'd0;
            coalesce_cnt <= 8'd0;
        end else begin
            rd_pend_p1 <= rd_pend;
            wr_pend_p1 <= wr_pend;
            if (rd_irq && (!rd_pend || rd_clr)) begin
                rd_pend  <= 1'b1;
                rd_num_q <= rd_irq_num;
            end else if (rd_clr) begin
                rd_pend  <= 1'b0;
            end
            if (wr_irq && (!wr_pend || wr_clr)) begin
                wr_pend  <= 1'b1;
                wr_num_q <= wr_irq_num;
            end else if (wr_clr) begin
                wr_pend  <= 1'b0;
            end
            coalesce_cnt <= sat_inc(coalesce_cnt, {1'b0, rd_merge} + {1'b0, wr_merge});
        end
    end

    // Request FSM with registered outputs
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            app_msi_req <= 1'b0;
            app_msi_tc  <= 3'd0;
            app_msi_num <= 5'd0;
            gap_cnt     <= 4'd0;
            last_gnt    <= SRC_WR;
            gnt_q       <= SRC_WR;
        end else begin
            unique case (state)
                IDLE: begin
                    if (msi_enable && (rd_rdy || wr_rdy)) begin
                        state       <= REQ;
                        app_msi_req <= 1'b1;
                        app_msi_tc  <= MSI_TC;
                        app_msi_num <= (gnt_sel == SRC_WR) ? wr_num_q : rd_num_q;
                        gnt_q       <= gnt_sel;
                    end
                end
                REQ: begin
                    if (app_msi_ack) begin
                        state       <= GAP;
                        app_msi_req <= 1'b0;
                        last_gnt    <= gnt_q;
                        gap_cnt     <= 4'(GAP_CYCLES);
                    end
                end
                GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state   <= IDLE;
                        gap_cnt <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign msi_busy = rd_pend || wr_pend || (state != IDLE);

endmodule

// File: tb/tb_altpcierd_cdma_msi_gen.sv
// Bench for altpcierd_cdma_msi_gen: vector table plus corner-case sequences,
// with expected MSI numbers queued and checked as each request rises.
module tb_altpcierd_cdma_msi_gen;
    localparam int GAP = 4;

    logic       clk_in = 1'b0;
    logic       rstn, msi_enable, rd_irq, wr_irq, app_msi_ack;
    logic [4:0] rd_irq_num, wr_irq_num;
    logic       app_msi_req, msi_busy;
    logic [2:0] app_msi_tc;
    logic [4:0] app_msi_num;
    logic [7:0] coalesce_cnt;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic req_prev = 1'b0;

    always #5 clk_in = ~clk_in;

    altpcierd_cdma_msi_gen #(.MSI_TC(3'd0), .GAP_CYCLES(GAP)) dut (
        .clk_in(clk_in), .rstn(rstn), .msi_enable(msi_enable),
        .rd_irq(rd_irq), .rd_irq_num(rd_irq_num),
        .wr_irq(wr_irq), .wr_irq_num(wr_irq_num),
        .app_msi_req(app_msi_req), .app_msi_ack(app_msi_ack),
        .app_msi_tc(app_msi_tc), .app_msi_num(app_msi_num),
        .msi_busy(msi_busy), .coalesce_cnt(coalesce_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every rising request must match the oldest expected number.
    always @(negedge clk_in) begin
        if (rstn && app_msi_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got num %0d, expected no request", app_msi_num);
            end else begin
                chk("msi_num", app_msi_num, exp_q.pop_front());
                chk("msi_tc", app_msi_tc, 3'd0);
            end
        end
        req_prev <= rstn ? app_msi_req : 1'b0;
    end

    task automatic do_reset();
        rstn = 1'b0; msi_enable = 1'b0; rd_irq = 1'b0; wr_irq = 1'b0;
        rd_irq_num = 5'd0; wr_irq_num = 5'd0; app_msi_ack = 1'b0;
        repeat (2) @(negedge clk_in);
        rstn = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic pulse(input logic r, input logic [4:0] rn, input logic w, input logic [4:0] wn);
        rd_irq = r; rd_irq_num = rn; wr_irq = w; wr_irq_num = wn;
        @(negedge clk_in);
        rd_irq = 1'b0; wr_irq = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!app_msi_req && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        if (!app_msi_req) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got req=0 after %0d cycles, expected req=1", name, n);
        end
    endtask

    task automatic serve(input string name);
        wait_req(name);
        if (app_msi_req) begin
            app_msi_ack = 1'b1;
            @(negedge clk_in);
            app_msi_ack = 1'b0;
            chk({name, "_drop"}, app_msi_req, 1'b0);
        end
    endtask

    typedef struct {
        logic       rd;
        logic [4:0] rn;
        logic       wr;
        logic [4:0] wn;
        int         n_exp;
        logic [4:0] e0;
        logic [4:0] e1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int c;
        vecs[0] = '{1'b1, 5'd1,  1'b1, 5'd2,  2, 5'd1,  5'd2};
        vecs[1] = '{1'b1, 5'd7,  1'b0, 5'd0,  1, 5'd7,  5'd0};
        vecs[2] = '{1'b0, 5'd0,  1'b1, 5'd9,  1, 5'd9,  5'd0};
        vecs[3] = '{1'b1, 5'd31, 1'b1, 5'd0,  2, 5'd31, 5'd0};

        rstn = 1'b0; msi_enable = 1'b0; rd_irq = 1'b0; wr_irq = 1'b0;
        rd_irq_num = 5'd0; wr_irq_num = 5'd0; app_msi_ack = 1'b0;
        #12;
        chk("rst_req", app_msi_req, 1'b0);
        chk("rst_tc", app_msi_tc, 3'd0);
        chk("rst_num", app_msi_num, 5'd0);
        chk("rst_busy", msi_busy, 1'b0);
        chk("rst_coal", coalesce_cnt, 8'd0);

        // Latency, hold, ack and minimum gap (ack held high during GAP/IDLE is ignored)
        do_reset();
        msi_enable = 1'b1;
        exp_q.push_back(5);
        pulse(1'b1, 5'd5, 1'b0, 5'd0);
        chk("lat_n0", app_msi_req, 1'b0);
        @(negedge clk_in);
        chk("lat_n1", app_msi_req, 1'b0);
        @(negedge clk_in);
        chk("lat_n2", app_msi_req, 1'b1);
        chk("lat_busy", msi_busy, 1'b1);
        repeat (2) @(negedge clk_in);
        msi_enable = 1'b0;
        @(negedge clk_in);
        chk("hold_req", app_msi_req, 1'b1);
        chk("hold_num", app_msi_num, 5'd5);
        msi_enable = 1'b1;
        app_msi_ack = 1'b1;
        @(negedge clk_in);
        chk("ack_drop", app_msi_req, 1'b0);
        exp_q.push_back(6);
        pulse(1'b1, 5'd6, 1'b0, 5'd0);
        c = 0;
        while (!app_msi_req && c < 40) begin
            @(negedge clk_in);
            c++;
        end
        app_msi_ack = 1'b0;
        chk("gap_wait", c, GAP);
        serve("gap_second");
        repeat (GAP + 4) @(negedge clk_in);
        chk("gap_sb_empty", exp_q.size(), 0);

        // Vector table: simultaneous/single pulses straight after reset
        for (int i = 0; i < 4; i++) begin
            do_reset();
            msi_enable = 1'b1;
            exp_q.push_back(int'(vecs[i].e0));
            if (vecs[i].n_exp > 1) exp_q.push_back(int'(vecs[i].e1));
            pulse(vecs[i].rd, vecs[i].rn, vecs[i].wr, vecs[i].wn);
            for (int k = 0; k < vecs[i].n_exp; k++) serve($sformatf("vec%0d_%0d", i, k));
            repeat (GAP + 4) @(negedge clk_in);
            chk($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
            chk($sformatf("vec%0d_idle", i), msi_busy, 1'b0);
        end

        // Round robin: after RD was served, a tie goes to WR
        do_reset();
        msi_enable = 1'b1;
        exp_q.push_back(3);
        pulse(1'b1, 5'd3, 1'b0, 5'd0);
        serve("rr_first");
        repeat (GAP + 2) @(negedge clk_in);
        exp_q.push_back(14);
        exp_q.push_back(13);
        pulse(1'b1, 5'd13, 1'b1, 5'd14);
        serve("rr_wr");
        serve("rr_rd");
        repeat (GAP + 4) @(negedge clk_in);
        chk("rr_sb_empty", exp_q.size(), 0);

        // Coalescing while disabled, then enable releases exactly one MSI
        do_reset();
        pulse(1'b0, 5'd0, 1'b1, 5'd4);
        for (int i = 0; i < 3; i++) pulse(1'b0, 5'd0, 1'b1, 5'(9 + i));
        chk("coal3_cnt", coalesce_cnt, 8'd3);
        chk("coal3_busy", msi_busy, 1'b1);
        chk("coal3_noreq", app_msi_req, 1'b0);
        exp_q.push_back(4);
        msi_enable = 1'b1;
        serve("coal3");
        repeat (GAP + 4) @(negedge clk_in);
        chk("coal3_sb_empty", exp_q.size(), 0);
        chk("coal3_cnt_after", coalesce_cnt, 8'd3);

        // Saturation and enable gating: RD wins the tie since WR was served last
        msi_enable = 1'b0;
        pulse(1'b0, 5'd0, 1'b1, 5'd20);
        for (int i = 0; i < 300; i++) pulse(1'b0, 5'd0, 1'b1, 5'd1);
        chk("coal_sat", coalesce_cnt, 8'd255);
        pulse(1'b1, 5'd12, 1'b0, 5'd0);
        repeat (5) @(negedge clk_in);
        chk("dis_noreq", app_msi_req, 1'b0);
        chk("dis_busy", msi_busy, 1'b1);
        exp_q.push_back(12);
        exp_q.push_back(20);
        msi_enable = 1'b1;
        @(negedge clk_in);
        chk("en_req", app_msi_req, 1'b1);
        serve("en_rd");
        serve("en_wr");
        repeat (GAP + 4) @(negedge clk_in);
        chk("en_sb_empty", exp_q.size(), 0);
        chk("coal_sat_hold", coalesce_cnt, 8'd255);

        // Pulse on the same edge as the ack of that source re-arms it without coalescing
        do_reset();
        msi_enable = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(8);
        pulse(1'b0, 5'd0, 1'b1, 5'd3);
        wait_req("reack");
        app_msi_ack = 1'b1; wr_irq = 1'b1; wr_irq_num = 5'd8;
        @(negedge clk_in);
        app_msi_ack = 1'b0; wr_irq = 1'b0;
        chk("reack_drop", app_msi_req, 1'b0);
        chk("reack_busy", msi_busy, 1'b1);
        chk("reack_coal", coalesce_cnt, 8'd0);
        serve("reack_second");
        repeat (GAP + 4) @(negedge clk_in);
        chk("reack_sb_empty", exp_q.size(), 0);
        chk("reack_coal_after", coalesce_cnt, 8'd0);

        // Asynchronous reset in REQ drops the request at once and discards pending state
        do_reset();
        msi_enable = 1'b1;
        exp_q.push_back(10);
        pulse(1'b1, 5'd10, 1'b1, 5'd11);
        wait_req("arst");
        #2 rstn = 1'b0;
        #1;
        chk("arst_req", app_msi_req, 1'b0);
        chk("arst_num", app_msi_num, 5'd0);
        chk("arst_busy", msi_busy, 1'b0);
        @(negedge clk_in);
        rstn = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("arst_noreq", app_msi_req, 1'b0);
        chk("arst_idle", msi_busy, 1'b0);
        exp_q.push_back(17);
        pulse(1'b1, 5'd17, 1'b0, 5'd0);
        serve("arst_new");
        repeat (GAP + 4) @(negedge clk_in);
        chk("arst_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
